pipeline_stage_reg: RTL

Generic, parametrised inter-stage pipeline register for the RV32E core. It replaces hand-written per-stage registers such as ID/EX and EX/MEM. It carries an opaque data payload plus a control field that is forced to a safe "kill" encoding on bubbles. Handshake is valid/ready with synchronous flush and an invalid-tag passthrough. An optional skid slot lets `in_ready` be registered, and a saturating stall counter supports performance analysis.

---
 rtl/pipeline_stage_reg_pkg.sv | 26 ++
 rtl/pipeline_stage_reg_if.sv | 34 +++
 rtl/pipeline_stage_reg_slot.sv | 76 +++++++
 rtl/pipeline_stage_reg.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/pipeline_stage_reg_pkg.sv
// ---------------------------------------------------------------------------
// pipeline_pkg : shared state encoding and per-stage control constants
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package pipeline_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

  // ID/EX ctrl layout: {regfile_we, mem_re, mem_we, alu_src, wb_sel, branch[2:0]}
  localparam int ID_EX_CTRL_W  = 8;
  localparam int EX_MEM_CTRL_W = 4;

  localparam logic [2:0] BRANCH_FORCE_FALSE = 3'b010;

  localparam logic [ID_EX_CTRL_W-1:0]  ID_EX_KILL  = {5'b00000, BRANCH_FORCE_FALSE};
  localparam logic [EX_MEM_CTRL_W-1:0] EX_MEM_KILL = '0;

endpackage

`default_nettype wire

// File: rtl/pipeline_stage_reg_if.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg_if : upstream/downstream valid-ready bus of one stage
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface pipeline_stage_reg_if #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic              in_invalid;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic              out_invalid;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;

  modport slave (
    input  in_valid, in_invalid, in_data, in_ctrl, flush, out_ready,
    output in_ready, out_valid, out_invalid, out_data, out_ctrl
  );

  modport master (
    output in_valid, in_invalid, in_data, in_ctrl, flush, out_ready,
    input  in_ready, out_valid, out_invalid, out_data, out_ctrl
  );
endinterface

`default_nettype wire

// File: rtl/pipeline_stage_reg_slot.sv
// ---------------------------------------------------------------------------
// pipeline_slot : one beat register (valid/invalid/data/ctrl) with load and kill
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_slot
  import pipeline_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] KILL_VALUE = '0
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  input  wire logic              clr,
  input  wire logic              load,
  input  wire logic              drain,
  input  wire logic              in_invalid,
  input  wire logic [DATA_W-1:0] in_data,
  input  wire logic [CTRL_W-1:0] in_ctrl,
  output logic                   valid,
  output logic                   invalid,
  output logic [DATA_W-1:0]      data,
  output logic [CTRL_W-1:0]      ctrl
);

  logic              valid_q, valid_d;
  logic              invalid_q, invalid_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;

  // Payload is left untouched on clear/drain; only ctrl is forced safe.
  always_comb begin
    valid_d   = valid_q;
    invalid_d = invalid_q;
    data_d    = data_q;
    ctrl_d    = ctrl_q;
    if (clr) begin
      valid_d   = 1'b0;
      invalid_d = 1'b0;
      ctrl_d    = KILL_VALUE;
    end else if (load) begin
      valid_d   = 1'b1;
      invalid_d = in_invalid;
      data_d    = in_data;
      ctrl_d    = in_invalid ? KILL_VALUE : in_ctrl;
    end else if (drain) begin
      valid_d   = 1'b0;
      invalid_d = 1'b0;
      ctrl_d    = KILL_VALUE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      invalid_q <= 1'b0;
      data_q    <= '0;
      ctrl_q    <= KILL_VALUE;
    end else begin
      valid_q   <= valid_d;
      invalid_q <= invalid_d;
      data_q    <= data_d;
      ctrl_q    <= ctrl_d;
    end
  end

  assign valid   = valid_q;
  assign invalid = invalid_q;
  assign data    = data_q;
  assign ctrl    = ctrl_q;

endmodule

`default_nettype wire

// File: rtl/pipeline_stage_reg.sv
// ---------------------------------------------------------------------------
// pipeline_stage_reg : generic inter-stage register, optional skid slot, stall counter
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module pipeline_stage_reg
  import pipeline_pkg::*;
#(
  parameter int                DATA_W     = 96,
  parameter int                CTRL_W     = 8,
  parameter logic [CTRL_W-1:0] KILL_VALUE = '0,
  parameter int                SKID       = 0,
  parameter int                CNT_W      = 16
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  pipeline_stage_reg_if.slave   bus,
  input  wire logic             stall_count_clr,
  output logic [CNT_W-1:0]      stall_count
);

  logic              accept;
  logic              emit;
  logic              o_valid;
  logic              o_invalid;
  logic [DATA_W-1:0] o_data;
  logic [CTRL_W-1:0] o_ctrl;

  assign accept          = bus.in_valid & bus.in_ready;
  assign emit            = o_valid & bus.out_ready;
  assign bus.out_valid   = o_valid;
  assign bus.out_invalid = o_invalid;
  assign bus.out_data    = o_data;
  assign bus.out_ctrl    = o_ctrl;

  generate
    if (SKID == 0) begin : g_single
      assign bus.in_ready = rst_n & (!o_valid | bus.out_ready);

      pipeline_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_VALUE(KILL_VALUE)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.flush),
        .load       (accept),
        .drain      (emit),
        .in_invalid (bus.in_invalid),
        .in_data    (bus.in_data),
        .in_ctrl    (bus.in_ctrl),
        .valid      (o_valid),
        .invalid    (o_invalid),
        .data       (o_data),
        .ctrl       (o_ctrl)
      );
    end else begin : g_skid
      stage_state_t      state_q, state_d;
      logic              ready_q, ready_d;
      logic              o_load, o_drain, s_load, s_drain, o_from_skid;
      logic              s_valid, s_invalid;
      logic [DATA_W-1:0] s_data;
      logic [CTRL_W-1:0] s_ctrl;

      always_comb begin
        state_d     = state_q;
        o_load      = 1'b0;
        o_drain     = 1'b0;
        s_load      = 1'b0;
        s_drain     = 1'b0;
        o_from_skid = 1'b0;
        if (bus.flush) begin
          state_d = EMPTY;
        end else begin
          case (state_q)
            EMPTY: if (accept) begin
              o_load  = 1'b1;
              state_d = ONE;
            end
            ONE: if (accept && emit) begin
              o_load = 1'b1;
            end else if (accept) begin
              s_load  = 1'b1;
              state_d = TWO;
            end else if (emit) begin
              o_drain = 1'b1;
              state_d = EMPTY;
            end
            TWO: if (emit && s_valid) begin
              o_load      = 1'b1;
              o_from_skid = 1'b1;
              s_drain     = 1'b1;
              state_d     = ONE;
            end
            default: state_d = EMPTY;
          endcase
        end
        ready_d = (state_d != TWO);
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          ready_q <= 1'b0;
        end else begin
          state_q <= state_d;
          ready_q <= ready_d;
        end
      end

      assign bus.in_ready = ready_q;

      pipeline_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_VALUE(KILL_VALUE)) u_out (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.flush),
        .load       (o_load),
        .drain      (o_drain),
        .in_invalid (o_from_skid ? s_invalid : bus.in_invalid),
        .in_data    (o_from_skid ? s_data    : bus.in_data),
        .in_ctrl    (o_from_skid ? s_ctrl    : bus.in_ctrl),
        .valid      (o_valid),
        .invalid    (o_invalid),
        .data       (o_data),
        .ctrl       (o_ctrl)
      );

      pipeline_slot #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .KILL_VALUE(KILL_VALUE)) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (bus.flush),
        .load       (s_load),
        .drain      (s_drain),
        .in_invalid (bus.in_invalid),
        .in_data    (bus.in_data),
        .in_ctrl    (bus.in_ctrl),
        .valid      (s_valid),
        .invalid    (s_invalid),
        .data       (s_data),
        .ctrl       (s_ctrl)
      );
    end
  endgenerate

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_count_clr) begin
      cnt_d = '0;
    end else if (o_valid && !bus.out_ready && !bus.flush && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign stall_count = cnt_q;

endmodule

`default_nettype wire
